// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one 8-bit combinational ALU between NREQ requesters.
// Accepted operands are registered, then the ALU result is registered and tagged with the requester id.
module alu_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_a,
  input  logic [8*NREQ-1:0] req_b,
  input  logic [3*NREQ-1:0] req_op,
  output logic [NREQ-1:0]   req_ready,
  output logic              resp_valid,
  output logic [IDW-1:0]    resp_id,
  output logic [7:0]        resp_data,
  output logic [15:0]       ops_done
);

  localparam int DATA_W = 8;

  function automatic logic [DATA_W-1:0] alu_f(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b,
                                              input logic [2:0]        op);
    logic [DATA_W-1:0] r;
    case (op)
      3'b000:  r = a + b;
      3'b001:  r = a - b;
      3'b010:  r = a & b;
      3'b011:  r = a | b;
      3'b100:  r = a ^ b;
      3'b101:  r = ~a;
      3'b110:  r = a << b[2:0];
      default: r = a >> b[2:0];
    endcase
    return r;
  endfunction

  logic [IDW-1:0]    last_grant_q, last_grant_d;
  logic [15:0]       ops_done_q, ops_done_d;
  logic [NREQ-1:0]   grant;
  logic [IDW-1:0]    gnt_id;
  logic [IDW-1:0]    idx;
  logic              accept;

  logic              vld_p0_q;
  logic [DATA_W-1:0] a_p0_q, b_p0_q;
  logic [2:0]        op_p0_q;
  logic [IDW-1:0]    id_p0_q;

  logic              vld_p1_q;
  logic [IDW-1:0]    id_p1_q;
  logic [DATA_W-1:0] data_p1_q;

  // Search starts just past the last winner, so the last winner has lowest priority.
  always_comb begin
    grant  = '0;
    gnt_id = '0;
    accept = 1'b0;
    idx    = '0;
    if (!hold && !rst) begin
      for (int k = 1; k <= NREQ; k++) begin
        idx = IDW'((int'(last_grant_q) + k) % NREQ);
        if (!accept && req_valid[idx]) begin
          accept      = 1'b1;
          grant[idx]  = 1'b1;
          gnt_id      = idx;
        end
      end
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    ops_done_d   = ops_done_q;
    if (accept) begin
      last_grant_d = gnt_id;
      ops_done_d   = ops_done_q + 16'd1;
    end
  end

  // Stage p0: operand capture on accept
  always_ff @(posedge clk) begin
    if (accept) begin
      a_p0_q  <= req_a[8*gnt_id +: 8];
      b_p0_q  <= req_b[8*gnt_id +: 8];
      op_p0_q <= req_op[3*gnt_id +: 3];
      id_p0_q <= gnt_id;
    end
  end

  // Stage p1: ALU result; result/id hold when no op is in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= IDW'(NREQ - 1);
      ops_done_q   <= '0;
      vld_p0_q     <= 1'b0;
      vld_p1_q     <= 1'b0;
      id_p1_q      <= '0;
      data_p1_q    <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      ops_done_q   <= ops_done_d;
      vld_p0_q     <= accept;
      vld_p1_q     <= vld_p0_q;
      if (vld_p0_q) begin
        id_p1_q   <= id_p0_q;
        data_p1_q <= alu_f(a_p0_q, b_p0_q, op_p0_q);
      end
    end
  end

  assign req_ready  = grant;
  assign resp_valid = vld_p1_q;
  assign resp_id    = id_p1_q;
  assign resp_data  = data_p1_q;
  assign ops_done   = ops_done_q;

endmodule
